// File: rtl/serial_addsub.sv
// Digit-serial add/subtract engine: DIGIT bits per clock, LSB-first, through a
// shared carry/borrow slice, with valid/ready on both sides and result flags.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // State table
    //   IDLE | waiting for an operand set, in_ready=1
    //   RUN  | processing one digit per clock
    //   DONE | result and flags presented until out_ready

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_mode;
    logic             chain;
    logic             chain_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT-1:0] dsum;
    logic             accept;
    logic             last;
    logic             ovf_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & (state == IDLE);
    assign last      = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // One digit of the ripple chain; the chain register links consecutive digits.
    always_comb begin
        logic c;
        da   = op_a[cnt*DIGIT +: DIGIT];
        db   = op_b[cnt*DIGIT +: DIGIT];
        dsum = '0;
        c    = chain;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = da[i] ^ db[i] ^ c;
            if (op_mode) c = (da[i] & db[i]) | ((da[i] ^ db[i]) & c);
            else         c = (~da[i] & db[i]) | ((~da[i] | db[i]) & c);
        end
        chain_next = c;
        acc_next   = acc;
        acc_next[cnt*DIGIT +: DIGIT] = dsum;
        if (op_mode)
            ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (acc_next[WIDTH-1] != op_a[WIDTH-1]);
        else
            ovf_next = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (acc_next[WIDTH-1] != op_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_mode <= 1'b0;
            chain   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b;
            op_mode <= mode;
            chain   <= cin;
            cnt     <= '0;
            acc     <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            chain <= chain_next;
            cnt   <= cnt + 1'b1;
            // Outputs only change on the final digit, so no partial result is visible.
            if (last) begin
                result <= acc_next;
                cout   <= chain_next;
                ovf    <= ovf_next;
                zero   <= (acc_next == '0);
            end
        end
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle add/subtract engine; the sequential successor to the team's 4-bit ripple full-subtractor chain.
- Processes DIGIT bits per clock, LSB-first, through a shared borrow/carry slice. Area scales with DIGIT, not WIDTH.
- Adds a valid/ready handshake on both sides, a per-operation add/sub mode, and status flags (carry/borrow out, signed overflow, zero).
- Sits between an operand source and a result consumer in datapaths where area matters more than latency.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. Must divide WIDTH exactly.
- N (derived, not overridable): WIDTH/DIGIT, the number of compute cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  engine can accept an operand set
- mode  input  1  0 = subtract (a - b - cin), 1 = add (a + b + cin)
- a  input  WIDTH  minuend / addend
- b  input  WIDTH  subtrahend / addend
- cin  input  1  borrow-in (subtract) or carry-in (add)
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  difference or sum, modulo 2^WIDTH
- cout  output  1  borrow-out (subtract) or carry-out (add) from the MSB
- ovf  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - in_ready=1; out_valid=0; result, cout, ovf, zero all 0.
  - Internal operand, counter and carry registers are cleared.
  - Reset overrides every other event and aborts any operation in RUN or DONE. No partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready, capture a, b, mode and cin, clear the digit counter, and go to RUN.
  - Without in_valid, stay in IDLE.
- RUN:
  - in_ready=0.
  - On each edge, process digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1), rippling the chain bit-to-bit inside the digit and across digits through a carry register.
  - Per-bit subtract: d = a^b^br; br_next = (~a & b) | ((~a | b) & br).
  - Per-bit add: s = a^b^c; c_next = (a & b) | ((a ^ b) & c).
  - On the edge that processes digit N-1: go to DONE, set out_valid=1, and drive result, cout, ovf and zero.
  - out_valid therefore first rises exactly N edges after the accepting edge.
- Flags:
  - cout is the chain value leaving bit WIDTH-1.
  - Subtract: ovf = (a[MSB] != b[MSB]) & (result[MSB] != a[MSB]).
  - Add: ovf = (a[MSB] == b[MSB]) & (result[MSB] != a[MSB]).
  - zero = (result == 0).
- DONE:
  - out_valid=1; outputs are held stable while out_ready=0.
  - On the edge with out_ready=1: out_valid goes to 0, state goes to IDLE, and in_ready=1 from the next cycle.
  - Outputs keep their last values after the handshake.
  - in_valid is ignored in RUN and DONE. Operands are not queued.
- Input stability: inputs changing during RUN have no effect, because operands are registered at acceptance.
- Throughput: at best one operation per N+2 cycles (accept, N compute edges, result handshake, return to IDLE).
- Wrap-around: results are modulo 2^WIDTH. Example: a=0, b=0, cin=1, subtract gives all-ones with cout=1.

Test Plan:
1. WIDTH=8, DIGIT=1, subtract 0x0F-0x03, cin=0, out_ready=1 -> out_valid high 8 edges after accept; result=0x0C, cout=0, ovf=0, zero=0.
2. Subtract 0x03-0x0F, cin=0 -> result=0xF4, cout=1, ovf=0. Then subtract 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
3. Add 0xFF+0x01, cin=0 -> result=0x00, cout=1, zero=1, ovf=0. Then add 0x7F+0x00, cin=1 -> result=0x80, ovf=1, cout=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands -> result and flags unchanged, in_ready=0 throughout, new operands not taken; out_ready=1 -> IDLE, next operation accepted normally.
5. Assert rst_n=0 for one cycle at RUN digit 3 -> all outputs 0, in_ready=1; subtract 0x10-0x01 issued next -> result=0x0F, cout=0, with no residue from the aborted operation.
6. WIDTH=16, DIGIT=4: subtract 0x1234-0x4321, cin=1 -> out_valid 4 edges after accept; result=0xCF12, cout=1, ovf=0.
